axi_rd_arbiter: RTL and testbench

Per-slave read-channel arbiter for the crossbar, in the AXI clock domain. It sits between the two master-side interface units (M0 and M1) and one slave port (S0..S5); one instance per slave. It grants the slave's AR channel to one master at a time using round-robin, and holds that grant until the granted burst's last R beat. It then routes R-channel valid/ready to the owner and checks the burst's beat count against ARLEN.

---
 rtl/axi_rd_arbiter.sv | 120 ++++++++++++
 tb/tb_axi_rd_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// Per-slave AXI read-channel arbiter: round-robin AR grant between two masters,
// grant held until the burst's RLAST beat, R handshake routed to the owner, beat count checked against ARLEN.
module axi_rd_arbiter #(
  parameter int DATA_W  = 49,
  parameter int LEN_LSB = 5
) (
  input  logic              AXI_CLK_i,
  input  logic              AXI_RST_i,
  input  logic [1:0]        REQ_VALID_i,
  input  logic [DATA_W-1:0] REQ_DATA_M0_i,
  input  logic [DATA_W-1:0] REQ_DATA_M1_i,
  output logic [1:0]        REQ_READY_o,
  output logic              ARVALID_o,
  output logic [DATA_W-1:0] AR_DATA_o,
  input  logic              ARREADY_i,
  input  logic              RVALID_i,
  input  logic              RLAST_i,
  output logic              RREADY_o,
  output logic [1:0]        RVALID_o,
  input  logic [1:0]        RREADY_i,
  output logic [1:0]        GRANT_o,
  output logic              LEN_ERR_o,
  output logic              BUSY_o,
  output logic [1:0]        DBG_STATE_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  // Handshake rule on every channel: a transfer happens on a rising edge where
  // valid and ready are both high; valid-side payload is held stable until then.

  logic [1:0]        r_state;
  logic              r_last;
  logic              r_owner;
  logic [DATA_W-1:0] r_ar_data;
  logic [3:0]        r_cnt;
  logic [3:0]        r_exp_len;
  logic              r_len_err;

  logic w_req_any;
  logic w_sel;
  logic w_grant_take;
  logic w_owner_ready;
  logic w_beat;

  // On a tie the master that did not own the previous burst wins.
  assign w_req_any     = |REQ_VALID_i;
  assign w_sel         = (REQ_VALID_i == 2'b11) ? ~r_last : REQ_VALID_i[1];
  assign w_grant_take  = (r_state == S_IDLE) && w_req_any && !AXI_RST_i;
  assign w_owner_ready = r_owner ? RREADY_i[1] : RREADY_i[0];
  assign w_beat        = (r_state == S_DATA) && RVALID_i && w_owner_ready;

  always_comb begin
    REQ_READY_o = 2'b00;
    RVALID_o    = 2'b00;
    RREADY_o    = 1'b0;
    GRANT_o     = 2'b00;
    if (w_grant_take) begin
      REQ_READY_o = w_sel ? 2'b10 : 2'b01;
    end
    if (r_state == S_DATA) begin
      RVALID_o = r_owner ? {RVALID_i, 1'b0} : {1'b0, RVALID_i};
      RREADY_o = w_owner_ready;
    end
    if (r_state != S_IDLE) begin
      GRANT_o = r_owner ? 2'b10 : 2'b01;
    end
  end

  assign ARVALID_o   = (r_state == S_ADDR);
  assign AR_DATA_o   = r_ar_data;
  assign BUSY_o      = (r_state != S_IDLE);
  assign LEN_ERR_o   = r_len_err;
  assign DBG_STATE_o = r_state;

  always_ff @(posedge AXI_CLK_i) begin
    if (AXI_RST_i) begin
      r_state   <= S_IDLE;
      r_last    <= 1'b1;
      r_owner   <= 1'b0;
      r_ar_data <= '0;
      r_cnt     <= 4'd0;
      r_exp_len <= 4'd0;
      r_len_err <= 1'b0;
    end else begin
      r_len_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req_any) begin
            r_owner   <= w_sel;
            r_ar_data <= w_sel ? REQ_DATA_M1_i : REQ_DATA_M0_i;
            r_state   <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (ARREADY_i) begin
            r_cnt     <= 4'd0;
            r_exp_len <= r_ar_data[LEN_LSB +: 4];
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_beat) begin
            r_cnt <= r_cnt + 4'd1;
            // The pre-increment count equals ARLEN on the final beat of a well-formed burst.
            if (RLAST_i) begin
              r_state   <= S_IDLE;
              r_last    <= r_owner;
              r_len_err <= (r_cnt != r_exp_len);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: burst-level reference model feeds expected queues,
// a negedge monitor compares every DUT output against it.
module tb_axi_rd_arbiter;

  localparam int DATA_W  = 49;
  localparam int LEN_LSB = 5;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              AXI_RST_i = 1'b1;
  logic [1:0]        REQ_VALID_i = 2'b00;
  logic [DATA_W-1:0] REQ_DATA_M0_i = '0;
  logic [DATA_W-1:0] REQ_DATA_M1_i = '0;
  logic [1:0]        REQ_READY_o;
  logic              ARVALID_o;
  logic [DATA_W-1:0] AR_DATA_o;
  logic              ARREADY_i = 1'b0;
  logic              RVALID_i = 1'b0;
  logic              RLAST_i = 1'b0;
  logic              RREADY_o;
  logic [1:0]        RVALID_o;
  logic [1:0]        RREADY_i = 2'b00;
  logic [1:0]        GRANT_o;
  logic              LEN_ERR_o;
  logic              BUSY_o;
  logic [1:0]        dbg_state;

  axi_rd_arbiter #(.DATA_W(DATA_W), .LEN_LSB(LEN_LSB)) dut (
    .AXI_CLK_i    (clk),
    .AXI_RST_i    (AXI_RST_i),
    .REQ_VALID_i  (REQ_VALID_i),
    .REQ_DATA_M0_i(REQ_DATA_M0_i),
    .REQ_DATA_M1_i(REQ_DATA_M1_i),
    .REQ_READY_o  (REQ_READY_o),
    .ARVALID_o    (ARVALID_o),
    .AR_DATA_o    (AR_DATA_o),
    .ARREADY_i    (ARREADY_i),
    .RVALID_i     (RVALID_i),
    .RLAST_i      (RLAST_i),
    .RREADY_o     (RREADY_o),
    .RVALID_o     (RVALID_o),
    .RREADY_i     (RREADY_i),
    .GRANT_o      (GRANT_o),
    .LEN_ERR_o    (LEN_ERR_o),
    .BUSY_o       (BUSY_o),
    .DBG_STATE_o  (dbg_state)
  );

  // reference model: phase 0 = idle, 1 = address, 2 = data
  int   m_phase = 0;
  logic m_owner = 1'b0;
  logic m_last  = 1'b1;
  logic mon_en  = 1'b0;
  logic err_pending = 1'b0;

  logic [DATA_W+1:0] exp_ar_q[$];
  logic [0:0]        exp_err_q[$];

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] oh(input logic m);
    return m ? 2'b10 : 2'b01;
  endfunction

  function automatic logic pick(input logic [1:0] mask, input logic last);
    return (mask == 2'b11) ? ~last : mask[1];
  endfunction

  function automatic logic [DATA_W-1:0] rand_payload(input logic [3:0] len);
    logic [63:0] t;
    logic [DATA_W-1:0] p;
    t = {$urandom, $urandom};
    p = t[DATA_W-1:0];
    p[LEN_LSB +: 4] = len;
    return p;
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      logic [1:0] exp_rr;
      exp_rr = (m_phase == 0 && !AXI_RST_i && REQ_VALID_i != 2'b00) ? oh(pick(REQ_VALID_i, m_last)) : 2'b00;
      chk("busy", 64'(BUSY_o), 64'(m_phase != 0));
      chk("arvalid", 64'(ARVALID_o), 64'(m_phase == 1));
      chk("grant", 64'(GRANT_o), 64'((m_phase != 0) ? oh(m_owner) : 2'b00));
      chk("req_ready", 64'(REQ_READY_o), 64'(exp_rr));
      chk("rvalid", 64'(RVALID_o), 64'((m_phase == 2 && RVALID_i) ? oh(m_owner) : 2'b00));
      chk("rready", 64'(RREADY_o), 64'((m_phase == 2) ? RREADY_i[m_owner] : 1'b0));
      if (m_phase == 1) begin
        if (exp_ar_q.size() == 0) begin
          chk("ar_queue_empty", 64'(1), 64'(0));
        end else begin
          chk("ar_data", 64'(AR_DATA_o), 64'(exp_ar_q[0][DATA_W-1:0]));
          if (ARREADY_i) begin
            logic [DATA_W+1:0] e;
            e = exp_ar_q.pop_front();
            chk("ar_grant", 64'(GRANT_o), 64'(e[DATA_W+1:DATA_W]));
          end
        end
      end
      if (err_pending) begin
        err_pending = 1'b0;
        if (exp_err_q.size() == 0) chk("err_queue_empty", 64'(1), 64'(0));
        else chk("len_err", 64'(LEN_ERR_o), 64'(exp_err_q.pop_front()));
      end else begin
        chk("len_err_idle", 64'(LEN_ERR_o), 64'(0));
      end
      if (m_phase == 2 && RVALID_i && RREADY_i[m_owner] && RLAST_i) err_pending = 1'b1;
    end
  end

  // driver tasks (entered and left at #1 after a rising edge)
  task automatic do_reset();
    AXI_RST_i = 1'b1;
    REQ_VALID_i = 2'b00; ARREADY_i = 1'b0; RVALID_i = 1'b0; RLAST_i = 1'b0; RREADY_i = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    m_phase = 0; m_last = 1'b1;
    AXI_RST_i = 1'b0;
    chk("reset_ar_data", 64'(AR_DATA_o), 64'(0));
  endtask

  task automatic drive_beat_inputs(input logic v, input logic owner_rdy, input logic last);
    logic [1:0] rr;
    rr = 2'($urandom_range(0, 3));
    rr[m_owner] = owner_rdy;
    RVALID_i = v; RREADY_i = rr; RLAST_i = last;
  endtask

  task automatic do_burst(input logic [1:0] mask, input logic [3:0] len, input int nbeats,
                          input int ar_dly, input int bp_at, input int bp_len,
                          input bit hold_req, input int rst_after);
    logic w;
    logic [DATA_W-1:0] p0, p1;
    w  = pick(mask, m_last);
    p0 = rand_payload(len);
    p1 = rand_payload(len);
    REQ_VALID_i = mask; REQ_DATA_M0_i = p0; REQ_DATA_M1_i = p1;
    exp_ar_q.push_back({oh(w), w ? p1 : p0});
    if (rst_after < 0) exp_err_q.push_back(1'((((nbeats - 1) & 15)) != int'(len)));
    @(posedge clk); #1;
    m_owner = w; m_phase = 1;
    if (!hold_req) REQ_VALID_i = 2'b00;
    for (int d = 0; d < ar_dly; d++) begin
      RVALID_i = 1'($urandom); RLAST_i = 1'($urandom); RREADY_i = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
    end
    ARREADY_i = 1'b1;
    @(posedge clk); #1;
    ARREADY_i = 1'b0; m_phase = 2;
    for (int b = 0; b < nbeats; b++) begin
      if (b == rst_after) begin
        AXI_RST_i = 1'b1; RVALID_i = 1'b0; RLAST_i = 1'b0; RREADY_i = 2'b00;
        @(posedge clk); #1;
        AXI_RST_i = 1'b0; m_phase = 0; m_last = 1'b1;
        chk("rst_ar_data", 64'(AR_DATA_o), 64'(0));
        return;
      end
      if ($urandom_range(0, 3) == 0) begin
        drive_beat_inputs(1'b0, 1'($urandom), 1'($urandom));
        @(posedge clk); #1;
      end
      if (b == bp_at) begin
        for (int k = 0; k < bp_len; k++) begin
          drive_beat_inputs(1'b1, 1'b0, 1'($urandom));
          @(posedge clk); #1;
        end
      end
      drive_beat_inputs(1'b1, 1'b1, b == nbeats - 1);
      @(posedge clk); #1;
    end
    RVALID_i = 1'b0; RLAST_i = 1'b0; RREADY_i = 2'b00;
    m_phase = 0; m_last = w;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    do_reset();
    idle_cycles(2);

    // single M0, LEN 3, ARREADY after 2 cycles, 4 beats
    do_burst(2'b01, 4'd3, 4, 2, -1, 0, 1'b0, -1);
    idle_cycles(2);

    // both request continuously, LEN 0: M0, M1, M0, M1
    do_reset();
    for (int i = 0; i < 4; i++) do_burst(2'b11, 4'd0, 1, 0, -1, 0, i < 3, -1);
    idle_cycles(2);

    // M1 LEN 2 ends after 2 beats -> length error, then tie goes to M0
    do_burst(2'b10, 4'd2, 2, 1, -1, 0, 1'b0, -1);
    do_burst(2'b11, 4'd1, 2, 0, -1, 0, 1'b0, -1);
    idle_cycles(2);

    // owner backpressure mid-burst
    do_burst(2'b01, 4'd4, 5, 0, 2, 3, 1'b0, -1);
    idle_cycles(1);

    // reset in DATA after one of four beats, then tie goes to M0
    do_burst(2'b10, 4'd3, 4, 0, -1, 0, 1'b0, 1);
    idle_cycles(1);
    do_burst(2'b11, 4'd0, 1, 0, -1, 0, 1'b0, -1);

    // wrap boundary: 17 beats against LEN 0 matches modulo 16
    do_burst(2'b01, 4'd0, 17, 0, -1, 0, 1'b0, -1);
    do_burst(2'b10, 4'd15, 16, 1, 5, 2, 1'b0, -1);

    // randomized bursts
    for (int i = 0; i < 30; i++) begin
      logic [3:0] len;
      int nb;
      len = 4'($urandom_range(0, 15));
      nb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : int'(len) + 1;
      do_burst(2'($urandom_range(1, 3)), len, nb, int'($urandom_range(0, 3)),
               int'($urandom_range(0, nb)), int'($urandom_range(0, 3)),
               1'b0, -1);
      idle_cycles(int'($urandom_range(0, 2)));
    end

    idle_cycles(3);
    chk("ar_queue_drained", 64'(exp_ar_q.size()), 64'(0));
    chk("err_queue_drained", 64'(exp_err_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
